// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Owns HI/LO and models MULT/DIV latency with a busy counter.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] tmp_hi;
  logic [31:0] tmp_lo;

  logic        is_md;
  logic        is_div;
  logic        sdiv;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvsr;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign Busy = (cnt != 4'd0);

  // Decode the op and compute the would-be result of a MULT/DIV.
  // Division runs on magnitudes so INT_MIN / -1 wraps instead of trapping.
  always_comb begin
    is_md  = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      (mdu_op == OP_MULT),
      (mdu_op == OP_MULTU): is_md = 1'b1;
      (mdu_op == OP_DIV),
      (mdu_op == OP_DIVU): begin
        is_md  = 1'b1;
        is_div = 1'b1;
      end
      default: ;
    endcase
    sdiv   = (mdu_op == OP_DIV);
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = (sdiv && A[31]) ? -A : A;
    b_mag  = (sdiv && B[31]) ? -B : B;
    dvsr   = (B == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / dvsr;
    r_mag  = a_mag % dvsr;
    quot   = (sdiv && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem    = (sdiv && A[31]) ? -r_mag : r_mag;
    res_hi = HI;
    res_lo = LO;
    if (mdu_op == OP_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (mdu_op == OP_MULTU) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (is_div && B != 32'd0) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  assign Start = is_md && !Req && !Busy;

  // Move-from reads are purely combinational.
  always_comb begin
    MDUout = 32'd0;
    if (mdu_op == OP_MFHI) MDUout = HI;
    else if (mdu_op == OP_MFLO) MDUout = LO;
  end

  // HI/LO, staged result and latency counter; an in-flight op always
  // completes, new ops and moves are only taken while idle and unflushed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      HI     <= 32'd0;
      LO     <= 32'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      cnt    <= 4'd0;
    end else if (cnt != 4'd0) begin
      if (cnt == 4'd1) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
      cnt <= cnt - 4'd1;
    end else if (Start) begin
      tmp_hi <= res_hi;
      tmp_lo <= res_lo;
      cnt    <= is_div ? DIV_LAT : MUL_LAT;
    end else if (!Req) begin
      if (mdu_op == OP_MTHI) HI <= A;
      if (mdu_op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: table vectors, directed latency sequences and
// random traffic against a cycle-numbered reference model.
module tb_e_mdu;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUout;

  e_mdu #(.MULT_CYCLES(MLAT), .DIV_CYCLES(DLAT)) dut (
    .clk(clk), .reset(reset), .Req(Req), .mdu_op(mdu_op),
    .A(A), .B(B), .Start(Start), .Busy(Busy),
    .HI(HI), .LO(LO), .MDUout(MDUout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  // reference model: architectural HI/LO plus the window of cycles
  // during which a started op is outstanding
  int          cyc = 0;
  int          busy_from = 1;
  int          busy_until = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  typedef struct {
    bit          rst;
    bit          req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          st;
    bit          bz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy();
    return (cyc >= busy_from) && (cyc <= busy_until);
  endfunction

  function automatic bit m_start(input bit q, input logic [3:0] op);
    return (op >= 1 && op <= 4) && !q && !m_busy();
  endfunction

  function automatic logic [31:0] m_out(input logic [3:0] op);
    if (op == 5) return m_hi;
    if (op == 6) return m_lo;
    return 32'd0;
  endfunction

  task automatic calc(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b,
                      output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = m_hi;
    rl = m_lo;
    if (op == 1) begin
      p = sa * sb;
      rh = p[63:32]; rl = p[31:0];
    end else if (op == 2) begin
      p = {32'd0, a} * {32'd0, b};
      rh = p[63:32]; rl = p[31:0];
    end else if (op == 3 && b != 0) begin
      q = sa / sb;
      r = sa % sb;
      rh = r[31:0]; rl = q[31:0];
    end else if (op == 4 && b != 0) begin
      rh = a % b; rl = a / b;
    end
  endtask

  task automatic m_edge(input bit r, input bit q, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (!r) begin
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
      busy_from = 1; busy_until = 0;
    end else if (m_busy()) begin
      if (cyc == busy_until) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (m_start(q, op)) begin
      calc(op, a, b, p_hi, p_lo);
      busy_from  = cyc + 1;
      busy_until = cyc + ((op >= 3) ? DLAT : MLAT);
    end else if (!q) begin
      if (op == 7) m_hi = a;
      if (op == 8) m_lo = a;
    end
  endtask

  // one clock cycle: drive, compare against the model, advance
  task automatic apply(input bit r, input bit q, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit do_chk, output bit bz);
    reset = r; Req = q; mdu_op = op; A = a; B = b;
    #1;
    if (do_chk) begin
      chk("start", {31'd0, Start}, {31'd0, m_start(q, op)});
      chk("busy", {31'd0, Busy}, {31'd0, m_busy()});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
      chk("mduout", MDUout, m_out(op));
    end
    bz = Busy;
    m_edge(r, q, op, a, b);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // start an op, then idle (optionally with Req) until Busy drops
  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit req_busy, input int lat);
    bit bz;
    int n;
    n = 0;
    apply(1, 0, op, a, b, 1, bz);
    for (int i = 0; i < 40; i++) begin
      apply(1, req_busy, 0, 0, 0, 1, bz);
      if (!bz) break;
      n++;
    end
    chk({nm, "_lat"}, n, lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit bz;
    vec_t v;

    tbl.push_back('{1,0,4'd1,32'hFFFFFFFD,32'd5,1,0,0,0,0});
    for (int i = 0; i < MLAT; i++)
      tbl.push_back('{1,0,4'd0,0,0,0,1,0,0,0});
    tbl.push_back('{1,0,4'd6,0,0,0,0,32'hFFFFFFFF,32'hFFFFFFF1,32'hFFFFFFF1});
    tbl.push_back('{1,1,4'd7,32'h1234,0,0,0,32'hFFFFFFFF,32'hFFFFFFF1,0});
    tbl.push_back('{1,0,4'd7,32'h1234,0,0,0,32'hFFFFFFFF,32'hFFFFFFF1,0});
    tbl.push_back('{1,0,4'd5,0,0,0,0,32'h1234,32'hFFFFFFF1,32'h1234});
    tbl.push_back('{1,1,4'd2,32'hFFFFFFFF,32'hFFFFFFFF,0,0,32'h1234,32'hFFFFFFF1,0});
    tbl.push_back('{1,0,4'd0,0,0,0,0,32'h1234,32'hFFFFFFF1,0});

    apply(0, 0, 0, 0, 0, 0, bz);
    apply(0, 1, 0, 0, 0, 0, bz);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      reset = v.rst; Req = v.req; mdu_op = v.op; A = v.a; B = v.b;
      #1;
      chk($sformatf("tbl%0d_start", i), {31'd0, Start}, {31'd0, v.st});
      chk($sformatf("tbl%0d_busy", i), {31'd0, Busy}, {31'd0, v.bz});
      chk($sformatf("tbl%0d_hi", i), HI, v.hi);
      chk($sformatf("tbl%0d_lo", i), LO, v.lo);
      chk($sformatf("tbl%0d_mdu", i), MDUout, v.mo);
      apply(v.rst, v.req, v.op, v.a, v.b, 1, bz);
    end

    run_op("divu", 4, 7, 2, 0, DLAT);
    chk("divu_lo", LO, 3);
    chk("divu_hi", HI, 1);
    run_op("div", 3, -32'sd7, 2, 0, DLAT);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);
    run_op("multu_req", 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, MLAT);
    chk("multu_hi", HI, 32'hFFFFFFFE);
    chk("multu_lo", LO, 32'h00000001);
    run_op("divmin", 3, 32'h80000000, 32'hFFFFFFFF, 0, DLAT);
    chk("divmin_lo", LO, 32'h80000000);
    chk("divmin_hi", HI, 32'h0);

    apply(1, 0, 7, 32'hAA, 0, 1, bz);
    apply(1, 0, 8, 32'hBB, 0, 1, bz);
    run_op("div0", 3, 32'h55, 0, 0, DLAT);
    chk("div0_hi", HI, 32'hAA);
    chk("div0_lo", LO, 32'hBB);

    apply(1, 0, 3, 100, 7, 1, bz);
    apply(1, 0, 0, 0, 0, 1, bz);
    apply(1, 0, 0, 0, 0, 1, bz);
    apply(0, 1, 0, 0, 0, 1, bz);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    run_op("mult2", 1, 32'hFFFFFFFD, 5, 0, MLAT);
    chk("mult2_hi", HI, 32'hFFFFFFFF);
    chk("mult2_lo", LO, 32'hFFFFFFF1);

    for (int i = 0; i < 1500; i++) begin
      bit          r;
      bit          q;
      logic [3:0]  op;
      r  = ($urandom_range(0, 63) != 0);
      q  = ($urandom_range(0, 5) == 0);
      op = 4'($urandom_range(0, 15));
      if (m_busy() && ((op >= 1 && op <= 4) || op == 7 || op == 8))
        op = 4'd0;
      apply(r, q, op, pick(), pick(), 1, bz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
